// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and limits for the bit-serial adder.
// Holds the FSM state encoding and the maximum supported operand width.
package serial_adder_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the bit-serial adder.
// master drives start/a_in/b_in/cin; slave returns busy/done/sum/cout.
interface serial_adder_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_str.sv
// str: one-bit full-adder cell shared across the datapath.
// Ports: a, b, c (carry in) -> s (sum bit), co (carry out).
module str (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per clock via str.
// Ports: clk, rst (sync, active-high), bus (slave: start/a_in/b_in/cin in,
// busy/done/sum/cout out). {cout,sum} = a_in + b_in + cin after WIDTH cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH must be within 2..MAX_WIDTH");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;
    logic             s;
    logic             co;
    logic             accept;
    logic             last;

    str u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .c  (carry_q),
        .s  (s),
        .co (co)
    );

    // start is only honoured when no operation is in flight
    assign accept = bus.start && (state_q == IDLE || state_q == DONE);
    assign last   = (state_q == SHIFT) && (cnt_q == LAST);
    // new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
    assign acc_d  = {s, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = bus.start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == SHIFT);
        bus.done = (state_q == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            carry_q <= bus.cin;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (state_q == SHIFT) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            acc_q   <= acc_d;
            carry_q <= co;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                sum_q  <= acc_d;
                cout_q <= co;
            end
        end
    end

endmodule
